led_pattern_seq: RTL and testbench

Parametrised N-channel LED pattern sequencer for the board's RGB driver. It steps through a small, writable table of per-channel duty values at a programmable rate. Each channel gets a glitch-free PWM output, with optional linear fading between steps. Its outputs feed the PWM inputs of the hard RGB LED driver, replacing fixed counter-bit decoding with host-loadable colour sequences.

---
 rtl/led_seq_pkg.sv | 12 +
 rtl/led_pwm_ch.sv | 49 ++++
 rtl/led_pattern_seq.sv | 100 ++++++++++
 tb/tb_led_pattern_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared defaults and types for the LED pattern sequencer.
package led_seq_pkg;

    localparam int LED_SEQ_PWM_W    = 8;
    localparam int LED_SEQ_DIV_W    = 24;
    localparam int LED_SEQ_STEP_DIV = 12_000_000;
    localparam int LED_SEQ_DEPTH    = 4;

    // Duty value at the default PWM width.
    typedef logic [LED_SEQ_PWM_W-1:0] duty_t;

endpackage

// File: rtl/led_pwm_ch.sv
// One LED channel: duty latch at period boundaries plus registered PWM compare.
// Define LED_SEQ_FADE_EN to make the latch step 1 LSB toward the target instead of loading it.
module led_pwm_ch
    import led_seq_pkg::*;
#(
    parameter int PWM_W = LED_SEQ_PWM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             latch,
    input  logic [PWM_W-1:0] target,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             pwm_out
);

    logic [PWM_W-1:0] duty_cur_reg;
    logic [PWM_W-1:0] duty_next;
    logic             pwm_out_reg;

    always_comb begin
        duty_next = duty_cur_reg;
        if (latch) begin
`ifdef LED_SEQ_FADE_EN
            if (duty_cur_reg < target) begin
                duty_next = duty_cur_reg + PWM_W'(1);
            end else if (duty_cur_reg > target) begin
                duty_next = duty_cur_reg - PWM_W'(1);
            end
`else
            duty_next = target;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_cur_reg <= '0;
            pwm_out_reg  <= 1'b0;
        end else begin
            duty_cur_reg <= duty_next;
            // Counter never reaches all-ones, so a full-scale duty stays high.
            pwm_out_reg  <= en && (pwm_cnt < duty_cur_reg);
        end
    end

    assign pwm_out = pwm_out_reg;

endmodule

// File: rtl/led_pattern_seq.sv
// N-channel LED pattern sequencer: writable duty table stepped by a prescaler, per-channel PWM.
// Fading between steps is enabled in led_pwm_ch by defining LED_SEQ_FADE_EN.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int PWM_W    = LED_SEQ_PWM_W,
    parameter int DIV_W    = LED_SEQ_DIV_W,
    parameter int STEP_DIV = LED_SEQ_STEP_DIV,
    parameter int DEPTH    = LED_SEQ_DEPTH,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [NUM_CH*PWM_W-1:0] wr_data,
    input  logic [AW-1:0]           last_idx,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic [AW-1:0]           step_idx,
    output logic                    step_strobe
);

    localparam logic [PWM_W-1:0] PWM_TOP = {{(PWM_W-1){1'b1}}, 1'b0};
    localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(STEP_DIV - 1);

    logic [PWM_W-1:0]        pwm_cnt_reg, pwm_cnt_next;
    logic [DIV_W-1:0]        div_cnt_reg, div_cnt_next;
    logic [AW-1:0]           step_idx_reg, step_idx_next;
    logic                    step_strobe_reg, step_strobe_next;
    logic [NUM_CH*PWM_W-1:0] table_reg [DEPTH];
    logic [NUM_CH*PWM_W-1:0] cur_row;
    logic                    period_end;
    logic                    step_adv;

    assign period_end = en && (pwm_cnt_reg == PWM_TOP);
    assign step_adv   = en && (div_cnt_reg == DIV_TOP);
    // Read before any same-cycle write lands, so a colliding latch sees the old entry.
    assign cur_row    = table_reg[step_idx_reg];

    always_comb begin
        pwm_cnt_next     = '0;
        div_cnt_next     = '0;
        step_idx_next    = step_idx_reg;
        step_strobe_next = 1'b0;
        if (en) begin
            pwm_cnt_next     = period_end ? '0 : pwm_cnt_reg + PWM_W'(1);
            div_cnt_next     = step_adv ? '0 : div_cnt_reg + DIV_W'(1);
            step_strobe_next = step_adv;
            if (step_adv) begin
                step_idx_next = (step_idx_reg >= last_idx) ? '0 : step_idx_reg + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_reg     <= '0;
            div_cnt_reg     <= '0;
            step_idx_reg    <= '0;
            step_strobe_reg <= 1'b0;
        end else begin
            pwm_cnt_reg     <= pwm_cnt_next;
            div_cnt_reg     <= div_cnt_next;
            step_idx_reg    <= step_idx_next;
            step_strobe_reg <= step_strobe_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_reg[i] <= '0;
            end
        end else if (wr_en) begin
            table_reg[wr_addr] <= wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            led_pwm_ch #(
                .PWM_W(PWM_W)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .en     (en),
                .latch  (period_end),
                .target (cur_row[gi*PWM_W +: PWM_W]),
                .pwm_cnt(pwm_cnt_reg),
                .pwm_out(pwm_out[gi])
            );
        end
    endgenerate

    assign step_idx    = step_idx_reg;
    assign step_strobe = step_strobe_reg;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: 3 channels, 4-bit PWM (period 15), 40-cycle steps.
module tb_led_pattern_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [11:0] wr_data;
    logic [1:0]  last_idx;
    logic [2:0]  pwm_out;
    logic [1:0]  step_idx;
    logic        step_strobe;

    int total = 0;
    int bad   = 0;
    int k     = 0;   // index of the next rising edge in the current run

    typedef struct {
        int         k;
        logic       en;
        logic [1:0] last;
        logic [2:0] pwm;
        logic [1:0] idx;
        logic       strobe;
    } vec_t;

    vec_t tbl[$];

    led_pattern_seq #(
        .NUM_CH  (3),
        .PWM_W   (4),
        .DIV_W   (24),
        .STEP_DIV(40),
        .DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .last_idx   (last_idx),
        .pwm_out    (pwm_out),
        .step_idx   (step_idx),
        .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int t);
        while (k <= t) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic add(input int kk, input logic e, input logic [1:0] l,
                       input logic [2:0] p, input logic [1:0] i, input logic s);
        vec_t v;
        v.k = kk; v.en = e; v.last = l; v.pwm = p; v.idx = i; v.strobe = s;
        tbl.push_back(v);
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [11:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        check("reset pwm_out", 32'(pwm_out), 32'h0);
        check("reset step_idx", 32'(step_idx), 32'h0);
        check("reset step_strobe", 32'(step_strobe), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; last_idx = '0;
        do_reset();

`ifdef LED_SEQ_FADE_EN
        // Fade: ch0 target 4 from reset duty 0 -> 1,2,3,4,4 high cycles per period.
        begin
            int exp_hi [5] = '{1, 2, 3, 4, 4};
            write_entry(2'd0, 12'h004);
            en = 1'b1;
            k  = 0;
            for (int p = 0; p < 5; p++) begin
                int hi = 0;
                for (int e = 15 + 15 * p; e <= 29 + 15 * p; e++) begin
                    run_to(e);
                    if (pwm_out[0]) hi++;
                end
                check($sformatf("fade period %0d high count", p), 32'(hi), 32'(exp_hi[p]));
            end
        end
`else
        // entry0 = {ch2=0, ch1=15, ch0=5}, entry1 = {ch2=7, ch1=0, ch0=3}
        write_entry(2'd0, 12'h0F5);
        write_entry(2'd1, 12'h703);

        // k, en, last_idx | pwm_out, step_idx, step_strobe after edge k
        add(  0, 1, 0, 3'b000, 0, 0);
        add( 14, 1, 0, 3'b000, 0, 0);
        add( 15, 1, 0, 3'b011, 0, 0);   // first period with duty {0,15,5}
        add( 19, 1, 0, 3'b011, 0, 0);
        add( 20, 1, 0, 3'b010, 0, 0);
        add( 29, 1, 0, 3'b010, 0, 0);
        add( 39, 1, 0, 3'b010, 0, 1);   // strobe with last_idx=0 keeps step 0
        add( 40, 1, 1, 3'b010, 0, 0);
        add( 79, 1, 1, 3'b011, 1, 1);
        add( 89, 1, 1, 3'b010, 1, 0);
        add( 90, 1, 1, 3'b101, 1, 0);   // step 1 duties after boundary 89
        add( 93, 1, 1, 3'b100, 1, 0);
        add( 97, 1, 1, 3'b000, 1, 0);
        add(119, 1, 1, 3'b000, 0, 1);   // step and boundary together
        add(120, 1, 1, 3'b101, 0, 0);   // latch used pre-advance step 1
        add(135, 1, 1, 3'b011, 0, 0);
        add(159, 1, 1, 3'b010, 1, 1);
        add(160, 1, 0, 3'b010, 1, 0);   // lower last_idx below step_idx
        add(199, 1, 0, 3'b100, 0, 1);
        add(200, 1, 0, 3'b100, 0, 0);
        add(239, 1, 0, 3'b010, 0, 1);
        add(242, 1, 0, 3'b011, 0, 0);
        add(243, 0, 0, 3'b000, 0, 0);   // en dropped at pwm_cnt=3
        add(252, 0, 0, 3'b000, 0, 0);
        add(253, 1, 0, 3'b011, 0, 0);   // restart from pwm_cnt=0 with held duty
        add(258, 1, 0, 3'b010, 0, 0);
        add(279, 1, 0, 3'b010, 0, 0);
        add(292, 1, 0, 3'b010, 0, 1);   // prescaler restarted at re-enable

        k = 0;
        foreach (tbl[j]) begin
            run_to(tbl[j].k - 1);
            en       = tbl[j].en;
            last_idx = tbl[j].last;
            run_to(tbl[j].k);
            check($sformatf("k=%0d pwm_out", tbl[j].k), 32'(pwm_out), 32'(tbl[j].pwm));
            check($sformatf("k=%0d step_idx", tbl[j].k), 32'(step_idx), 32'(tbl[j].idx));
            check($sformatf("k=%0d step_strobe", tbl[j].k), 32'(step_strobe), 32'(tbl[j].strobe));
        end

        // Mid-period write to current step at pwm_cnt=2: ch0 5 -> 12.
        run_to(299);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 12'h0FC;
        run_to(300);
        wr_en = 1'b0;
        run_to(304); check("midwrite cnt6", 32'(pwm_out), 32'h2);
        run_to(308); check("midwrite cnt10", 32'(pwm_out), 32'h2);
        run_to(313); check("midwrite new cnt0", 32'(pwm_out), 32'h3);
        run_to(324); check("midwrite new cnt11", 32'(pwm_out), 32'h3);
        run_to(325); check("midwrite new cnt12", 32'(pwm_out), 32'h2);

        // Write on the boundary cycle: latch keeps 12, 3 applies one period later.
        run_to(326);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 12'h0F3;
        run_to(327);
        wr_en = 1'b0;
        check("collide boundary", 32'(pwm_out), 32'h2);
        run_to(328); check("collide old cnt0", 32'(pwm_out), 32'h3);
        run_to(331); check("collide old cnt3", 32'(pwm_out), 32'h3);
        run_to(345); check("collide new cnt2", 32'(pwm_out), 32'h3);
        run_to(346); check("collide new cnt3", 32'(pwm_out), 32'h2);

        // Reset wins over en and wr_en; table comes back cleared.
        rst = 1'b1; en = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 12'hFFF;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        check("rst override pwm_out", 32'(pwm_out), 32'h0);
        check("rst override step_idx", 32'(step_idx), 32'h0);
        check("rst override step_strobe", 32'(step_strobe), 32'h0);
        k = 0;
        run_to(15); check("post-reset table empty", 32'(pwm_out), 32'h0);
        run_to(38); check("post-reset no early strobe", 32'(step_strobe), 32'h0);
        run_to(39); check("post-reset strobe", 32'(step_strobe), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
